// File: rtl/sequence_pkg.sv
// rtl/sequence_pkg.sv - shared state encoding and default widths for the sequence step tracker
package sequence_pkg;

  localparam int PTR_W_DEFAULT  = 64;
  localparam int STEP_W_DEFAULT = 16;
  localparam int IDX_W_DEFAULT  = 16;
  localparam int CNT_W_DEFAULT  = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } state_e;

endpackage

// File: rtl/sequence_step_tracker_if.sv
// rtl/sequence_step_tracker_if.sv - control, pointer and status bundle of the step tracker
interface sequence_step_tracker_if
  import sequence_pkg::*;
#(
  parameter int PTR_W  = PTR_W_DEFAULT,
  parameter int STEP_W = STEP_W_DEFAULT,
  parameter int IDX_W  = IDX_W_DEFAULT,
  parameter int CNT_W  = CNT_W_DEFAULT
);

  logic              enable;
  logic [PTR_W-1:0]  writepointer;
  logic [STEP_W-1:0] step_size;
  logic [IDX_W-1:0]  steps_per_period;
  logic [CNT_W-1:0]  num_periods;

  logic [CNT_W-1:0]  step_counter;
  logic [IDX_W-1:0]  step_index;
  logic [CNT_W-1:0]  period_counter;
  logic              step_strobe;
  logic              period_strobe;
  logic              behind;
  logic              done;
  logic              cfg_error;

  // Acquisition side: drives pointer and run configuration, observes progress
  modport master (
    output enable, writepointer, step_size, steps_per_period, num_periods,
    input  step_counter, step_index, period_counter, step_strobe, period_strobe,
           behind, done, cfg_error
  );

  // Tracker side
  modport slave (
    input  enable, writepointer, step_size, steps_per_period, num_periods,
    output step_counter, step_index, period_counter, step_strobe, period_strobe,
           behind, done, cfg_error
  );

endinterface

// File: rtl/step_detect.sv
// rtl/step_detect.sv - registers the write pointer and compares its lead over base against the step size
module step_detect #(
  parameter int PTR_W  = 64,
  parameter int STEP_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [PTR_W-1:0]  writepointer_i,
  input  logic [PTR_W-1:0]  base_i,
  input  logic [STEP_W-1:0] step_size_i,
  output logic [PTR_W-1:0]  wp_q_o,
  output logic              step_hit_o,
  output logic              behind_hit_o
);

  logic [PTR_W-1:0] wp_q;
  logic [PTR_W-1:0] diff;
  logic [PTR_W:0]   diff_x;
  logic [PTR_W:0]   step_x;
  logic [PTR_W:0]   two_step_x;

  // Pointer is sampled once so the compare works from a stable registered value
  always_ff @(posedge clk) begin
    if (reset) begin
      wp_q <= '0;
    end else begin
      wp_q <= writepointer_i;
    end
  end

  // Modulo subtraction keeps pointer wrap transparent; compares run one bit wider
  // so doubling the step size can never overflow
  always_comb begin
    diff         = wp_q - base_i;
    diff_x       = {1'b0, diff};
    step_x       = (PTR_W + 1)'(step_size_i);
    two_step_x   = step_x << 1;
    step_hit_o   = diff_x >= step_x;
    behind_hit_o = diff_x >= two_step_x;
  end

  assign wp_q_o = wp_q;

endmodule

// File: rtl/sequence_step_tracker.sv
// rtl/sequence_step_tracker.sv - write-pointer driven sequence step, period and run tracker
module sequence_step_tracker
  import sequence_pkg::*;
#(
  parameter int PTR_W  = PTR_W_DEFAULT,
  parameter int STEP_W = STEP_W_DEFAULT,
  parameter int IDX_W  = IDX_W_DEFAULT,
  parameter int CNT_W  = CNT_W_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  sequence_step_tracker_if.slave bus
);

  state_e            state_q, state_d;
  logic              en_q;
  logic [PTR_W-1:0]  base_q, base_d;
  logic [PTR_W-1:0]  wp_q;
  logic [STEP_W-1:0] step_size_q, step_size_d;
  logic [IDX_W-1:0]  spp_q, spp_d;
  logic [CNT_W-1:0]  np_q, np_d;
  logic [CNT_W-1:0]  step_cnt_q, step_cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0]  per_q, per_d;
  logic              step_stb_q, step_stb_d;
  logic              per_stb_q, per_stb_d;
  logic              behind_q, behind_d;

  logic              step_hit;
  logic              behind_hit;
  logic              rise;
  logic              cfg_ok;
  logic              last_idx;
  logic              final_step;

  step_detect #(
    .PTR_W  (PTR_W),
    .STEP_W (STEP_W)
  ) u_detect (
    .clk            (clk),
    .reset          (reset),
    .writepointer_i (bus.writepointer),
    .base_i         (base_q),
    .step_size_i    (step_size_q),
    .wp_q_o         (wp_q),
    .step_hit_o     (step_hit),
    .behind_hit_o   (behind_hit)
  );

  // Next state, counter updates and strobes; enable low always wins and clears the run
  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    step_size_d = step_size_q;
    spp_d       = spp_q;
    np_d        = np_q;
    step_cnt_d  = step_cnt_q;
    idx_d       = idx_q;
    per_d       = per_q;
    step_stb_d  = 1'b0;
    per_stb_d   = 1'b0;
    behind_d    = 1'b0;

    rise       = bus.enable && !en_q;
    cfg_ok     = (bus.step_size != '0) && (bus.steps_per_period != '0);
    last_idx   = idx_q == (spp_q - IDX_W'(1));
    final_step = (np_q != '0) && last_idx && ((per_q + CNT_W'(1)) == np_q);

    if (!bus.enable) begin
      state_d    = IDLE;
      step_cnt_d = '0;
      idx_d      = '0;
      per_d      = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (rise) begin
            if (cfg_ok) begin
              // First cycle of a run only anchors base; no step is taken here
              state_d     = RUN;
              step_size_d = bus.step_size;
              spp_d       = bus.steps_per_period;
              np_d        = bus.num_periods;
              base_d      = wp_q;
              step_cnt_d  = '0;
              idx_d       = '0;
              per_d       = '0;
            end else begin
              state_d = ERR;
            end
          end
        end
        RUN: begin
          behind_d = behind_hit;
          if (step_hit) begin
            base_d     = base_q + PTR_W'(step_size_q);
            step_cnt_d = step_cnt_q + CNT_W'(1);
            step_stb_d = 1'b1;
            if (last_idx) begin
              idx_d     = '0;
              per_d     = per_q + CNT_W'(1);
              per_stb_d = 1'b1;
            end else begin
              idx_d = idx_q + IDX_W'(1);
            end
            if (final_step) begin
              state_d = DONE;
            end
          end
        end
        DONE: begin
          state_d = DONE;
        end
        ERR: begin
          state_d = ERR;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State and output registers; enable history follows enable through reset so a
  // level held high across reset is not mistaken for a new rising edge
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      en_q        <= bus.enable;
      base_q      <= '0;
      step_size_q <= '0;
      spp_q       <= '0;
      np_q        <= '0;
      step_cnt_q  <= '0;
      idx_q       <= '0;
      per_q       <= '0;
      step_stb_q  <= 1'b0;
      per_stb_q   <= 1'b0;
      behind_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      en_q        <= bus.enable;
      base_q      <= base_d;
      step_size_q <= step_size_d;
      spp_q       <= spp_d;
      np_q        <= np_d;
      step_cnt_q  <= step_cnt_d;
      idx_q       <= idx_d;
      per_q       <= per_d;
      step_stb_q  <= step_stb_d;
      per_stb_q   <= per_stb_d;
      behind_q    <= behind_d;
    end
  end

  assign bus.step_counter   = step_cnt_q;
  assign bus.step_index     = idx_q;
  assign bus.period_counter = per_q;
  assign bus.step_strobe    = step_stb_q;
  assign bus.period_strobe  = per_stb_q;
  assign bus.behind         = behind_q;
  assign bus.done           = (state_q == DONE);
  assign bus.cfg_error      = (state_q == ERR);

endmodule
